// File: rtl/seg7_pkg.sv
// Shared constants, FSM state type and select helpers
// for the seven-segment scan decoder.
package seg7_pkg;

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_SETTLE,
    ST_CAPTURE
  } state_t;

  localparam int NUM_POS   = 8;
  localparam int BUS_SPLIT = 4;
  localparam int SEG_DP    = 7;

  localparam logic [6:0] PAT_0     = 7'h3F;
  localparam logic [6:0] PAT_1     = 7'h06;
  localparam logic [6:0] PAT_2     = 7'h5B;
  localparam logic [6:0] PAT_3     = 7'h4F;
  localparam logic [6:0] PAT_4     = 7'h66;
  localparam logic [6:0] PAT_5     = 7'h6D;
  localparam logic [6:0] PAT_6     = 7'h7D;
  localparam logic [6:0] PAT_7     = 7'h07;
  localparam logic [6:0] PAT_8     = 7'h7F;
  localparam logic [6:0] PAT_9     = 7'h6F;
  localparam logic [6:0] PAT_A     = 7'h77;
  localparam logic [6:0] PAT_B     = 7'h7C;
  localparam logic [6:0] PAT_C     = 7'h39;
  localparam logic [6:0] PAT_D     = 7'h5E;
  localparam logic [6:0] PAT_E     = 7'h79;
  localparam logic [6:0] PAT_F     = 7'h71;
  localparam logic [6:0] PAT_BLANK = 7'h00;

  function automatic logic is_onehot(
    input logic [7:0] s
  );
    return (s != 8'h00) &&
           ((s & (s - 8'h01)) == 8'h00);
  endfunction

  function automatic logic [2:0] sel_index(
    input logic [7:0] s
  );
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_POS; i++)
      if (s[i]) idx = 3'(i);
    return idx;
  endfunction

endpackage

// File: rtl/seg7_scan_decoder_if.sv
// Scan-side inputs and decoded-frame outputs of the
// seven-segment scan decoder.
interface seg7_scan_decoder_if;
  logic [7:0]  seg7_sel;
  logic [7:0]  seg7;
  logic [7:0]  seg7_l;
  logic [31:0] digit_val;
  logic [7:0]  digit_blank;
  logic [7:0]  digit_dp;
  logic        frame_valid;
  logic        pat_err;
  logic        sel_err;
  logic        timeout;

  modport master (
    output seg7_sel, seg7, seg7_l,
    input  digit_val, digit_blank, digit_dp,
    input  frame_valid, pat_err, sel_err,
    input  timeout
  );

  modport slave (
    input  seg7_sel, seg7, seg7_l,
    output digit_val, digit_blank, digit_dp,
    output frame_valid, pat_err, sel_err,
    output timeout
  );
endinterface

// File: rtl/seg7_pat_decode.sv
// Seven-segment pattern {g..a} to hex nibble decoder
// with blank and illegal-pattern flags.
module seg7_pat_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pat,
  output logic [3:0] nibble,
  output logic       blank,
  output logic       illegal
);

  always_comb begin
    nibble  = 4'h0;
    blank   = 1'b0;
    illegal = 1'b0;
    case (pat)
      PAT_0:     nibble = 4'h0;
      PAT_1:     nibble = 4'h1;
      PAT_2:     nibble = 4'h2;
      PAT_3:     nibble = 4'h3;
      PAT_4:     nibble = 4'h4;
      PAT_5:     nibble = 4'h5;
      PAT_6:     nibble = 4'h6;
      PAT_7:     nibble = 4'h7;
      PAT_8:     nibble = 4'h8;
      PAT_9:     nibble = 4'h9;
      PAT_A:     nibble = 4'hA;
      PAT_B:     nibble = 4'hB;
      PAT_C:     nibble = 4'hC;
      PAT_D:     nibble = 4'hD;
      PAT_E:     nibble = 4'hE;
      PAT_F:     nibble = 4'hF;
      PAT_BLANK: blank  = 1'b1;
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Samples a multiplexed 8-digit seven-segment scan and
// publishes one decoded frame once every position is seen.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYC  = 2,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  seg7_sel,
  input  logic [7:0]  seg7,
  input  logic [7:0]  seg7_l,
  output logic [31:0] digit_val,
  output logic [7:0]  digit_blank,
  output logic [7:0]  digit_dp,
  output logic        frame_valid,
  output logic        pat_err,
  output logic        sel_err,
  output logic        timeout
);

  state_t      state, state_n;
  logic [7:0]  sel_q, seg_q, segl_q;
  logic [7:0]  sel_prev, bus_prev;
  logic [7:0]  sel_ref, bus_ref;
  logic [7:0]  bus_q;
  logic [31:0] stab_cnt, tcnt;
  logic [7:0]  mask;
  logic [31:0] sh_val;
  logic [7:0]  sh_blank, sh_dp;
  logic        chg, settle_done;
  logic        capture, sel_bad;
  logic [2:0]  idx;
  logic [3:0]  dec_nib;
  logic        dec_blank, dec_ill;

  assign bus_q = (|sel_q[7:BUS_SPLIT]) ? segl_q : seg_q;
  assign chg   = (sel_q != sel_prev) ||
                 (bus_q != bus_prev);
  assign settle_done = (state == ST_SETTLE) && !chg &&
                       (stab_cnt + 32'd1 >= STABLE_CYC);
  assign idx = sel_index(sel_ref);

  seg7_pat_decode u_dec (
    .pat     (bus_ref[6:0]),
    .nibble  (dec_nib),
    .blank   (dec_blank),
    .illegal (dec_ill)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_WAIT;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      ST_WAIT:
        if (sel_q != sel_ref) state_n = ST_SETTLE;
      ST_SETTLE:
        if (settle_done)
          state_n = is_onehot(sel_q) ? ST_CAPTURE
                                     : ST_WAIT;
      ST_CAPTURE: state_n = ST_WAIT;
      default:    state_n = ST_WAIT;
    endcase
  end

  always_comb begin
    capture = (state == ST_CAPTURE);
    sel_bad = settle_done && !is_onehot(sel_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_q       <= '0;
      seg_q       <= '0;
      segl_q      <= '0;
      sel_prev    <= '0;
      bus_prev    <= '0;
      sel_ref     <= '0;
      bus_ref     <= '0;
      stab_cnt    <= '0;
      tcnt        <= '0;
      mask        <= '0;
      sh_val      <= '0;
      sh_blank    <= '0;
      sh_dp       <= '0;
      digit_val   <= '0;
      digit_blank <= '0;
      digit_dp    <= '0;
      frame_valid <= 1'b0;
      pat_err     <= 1'b0;
      sel_err     <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      sel_q       <= seg7_sel;
      seg_q       <= seg7;
      segl_q      <= seg7_l;
      sel_prev    <= sel_q;
      bus_prev    <= bus_q;
      frame_valid <= 1'b0;
      timeout     <= 1'b0;
      sel_err     <= sel_bad;
      pat_err     <= capture && dec_ill;

      // The detecting WAIT cycle is the first stable sample.
      if (state == ST_WAIT)
        stab_cnt <= 32'd1;
      else if (state == ST_SETTLE)
        stab_cnt <= chg ? 32'd1 : stab_cnt + 32'd1;

      if (settle_done) begin
        sel_ref <= sel_q;
        bus_ref <= bus_q;
      end

      if (capture) begin
        sh_val[{idx, 2'b00} +: 4] <= dec_nib;
        sh_blank[idx]             <= dec_blank;
        sh_dp[idx]                <= bus_ref[SEG_DP];
      end

      if (mask == 8'hFF) begin
        digit_val   <= sh_val;
        digit_blank <= sh_blank;
        digit_dp    <= sh_dp;
        frame_valid <= 1'b1;
        mask        <= '0;
        tcnt        <= '0;
      end else if (tcnt == TIMEOUT_CYC - 1) begin
        timeout <= 1'b1;
        mask    <= '0;
        tcnt    <= '0;
      end else begin
        tcnt <= tcnt + 32'd1;
        if (capture) mask[idx] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed, table-driven bench for seg7_scan_decoder
// with hand-written multi-cycle corner sequences.
module tb_seg7_scan_decoder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  seg7_scan_decoder_if bus();

  seg7_scan_decoder #(
    .STABLE_CYC  (2),
    .TIMEOUT_CYC (64)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg7_sel    (bus.seg7_sel),
    .seg7        (bus.seg7),
    .seg7_l      (bus.seg7_l),
    .digit_val   (bus.digit_val),
    .digit_blank (bus.digit_blank),
    .digit_dp    (bus.digit_dp),
    .frame_valid (bus.frame_valid),
    .pat_err     (bus.pat_err),
    .sel_err     (bus.sel_err),
    .timeout     (bus.timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         pos;
    logic [7:0] seg;
    logic [3:0] nib;
    logic       blank;
    logic       dp;
  } vec_t;

  vec_t vt[16];
  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int fv_cnt = 0, pe_cnt = 0, se_cnt = 0, to_cnt = 0;
  int fv_last = 0, to_last = 0, to_prev = 0;

  always @(negedge clk) begin
    cyc++;
    if (bus.frame_valid) begin
      fv_cnt++;
      fv_last = cyc;
    end
    if (bus.pat_err) pe_cnt++;
    if (bus.sel_err) se_cnt++;
    if (bus.timeout) begin
      to_cnt++;
      to_prev = to_last;
      to_last = cyc;
    end
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic show(input int pos,
                      input logic [7:0] seg,
                      input int hold);
    bus.seg7_sel = 8'h01 << pos;
    if (pos < 4) bus.seg7 = seg;
    else         bus.seg7_l = seg;
    tick(hold);
  endtask

  task automatic wait_timeout();
    logic found;
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      tick(1);
      if (bus.timeout) found = 1'b1;
    end
    chk("wait_timeout", 32'(found), 32'd1);
  endtask

  task automatic chk_out(input string tag,
                         input logic [31:0] v,
                         input logic [7:0] b,
                         input logic [7:0] d);
    chk({tag, "_val"}, bus.digit_val, v);
    chk({tag, "_blank"}, 32'(bus.digit_blank), 32'(b));
    chk({tag, "_dp"}, 32'(bus.digit_dp), 32'(d));
  endtask

  task automatic run_table_frame(input int base,
                                 input int exp_pe);
    int fv0, pe0, to0;
    logic [31:0] ev;
    logic [7:0] eb, ed;
    ev = '0; eb = '0; ed = '0;
    wait_timeout();
    fv0 = fv_cnt; pe0 = pe_cnt; to0 = to_cnt;
    for (int i = 0; i < 8; i++) begin
      vec_t v;
      v = vt[base + i];
      show(v.pos, v.seg, 5);
      ev[v.pos*4 +: 4] = v.nib;
      eb[v.pos] = v.blank;
      ed[v.pos] = v.dp;
    end
    tick(2);
    chk("tbl_fv_cnt", 32'(fv_cnt - fv0), 32'd1);
    chk("tbl_pe_cnt", 32'(pe_cnt - pe0), 32'(exp_pe));
    chk("tbl_to_cnt", 32'(to_cnt - to0), 32'd0);
    chk("tbl_latency", 32'(fv_last - to_last), 32'd40);
    for (int p = 0; p < 8; p++) begin
      chk($sformatf("tbl_nib%0d", p),
          32'(bus.digit_val[p*4 +: 4]),
          32'(ev[p*4 +: 4]));
      chk($sformatf("tbl_blank%0d", p),
          32'(bus.digit_blank[p]), 32'(eb[p]));
      chk($sformatf("tbl_dp%0d", p),
          32'(bus.digit_dp[p]), 32'(ed[p]));
    end
  endtask

  initial begin
    int fv0, se0, pe0;

    vt[0]  = '{0, 8'h06, 4'h1, 1'b0, 1'b0};
    vt[1]  = '{1, 8'h3F, 4'h0, 1'b0, 1'b0};
    vt[2]  = '{2, 8'h4F, 4'h3, 1'b0, 1'b0};
    vt[3]  = '{3, 8'h3F, 4'h0, 1'b0, 1'b0};
    vt[4]  = '{4, 8'h7C, 4'hB, 1'b0, 1'b0};
    vt[5]  = '{5, 8'h00, 4'h0, 1'b1, 1'b0};
    vt[6]  = '{6, 8'h6D, 4'h5, 1'b0, 1'b0};
    vt[7]  = '{7, 8'h71, 4'hF, 1'b0, 1'b0};
    vt[8]  = '{0, 8'hF7, 4'hA, 1'b0, 1'b1};
    vt[9]  = '{1, 8'h39, 4'hC, 1'b0, 1'b0};
    vt[10] = '{2, 8'h49, 4'h0, 1'b0, 1'b0};
    vt[11] = '{3, 8'hF9, 4'hE, 1'b0, 1'b1};
    vt[12] = '{4, 8'h6F, 4'h9, 1'b0, 1'b0};
    vt[13] = '{5, 8'h07, 4'h7, 1'b0, 1'b0};
    vt[14] = '{6, 8'h5E, 4'hD, 1'b0, 1'b0};
    vt[15] = '{7, 8'hFD, 4'h6, 1'b0, 1'b1};

    bus.seg7_sel = '0;
    bus.seg7     = '0;
    bus.seg7_l   = '0;
    rst_n = 1'b0;
    tick(3);
    chk_out("rst", 32'h0, 8'h00, 8'h00);
    chk("rst_fv", 32'(bus.frame_valid), 32'd0);
    chk("rst_pe", 32'(bus.pat_err), 32'd0);
    chk("rst_se", 32'(bus.sel_err), 32'd0);
    chk("rst_to", 32'(bus.timeout), 32'd0);
    rst_n = 1'b1;

    run_table_frame(0, 0);
    chk_out("frameA", 32'hF50B0301, 8'h20, 8'h00);
    run_table_frame(8, 1);
    chk_out("frameB", 32'h6D79E0CA, 8'h00, 8'h89);

    // Bad select mid-frame, then overwrite of position 1.
    wait_timeout();
    fv0 = fv_cnt; se0 = se_cnt; pe0 = pe_cnt;
    show(0, 8'h66, 5);
    show(1, 8'h06, 5);
    show(2, 8'h5B, 5);
    show(3, 8'h71, 5);
    bus.seg7_sel = 8'h03;
    bus.seg7     = 8'h3F;
    tick(4);
    chk("selerr_cnt", 32'(se_cnt - se0), 32'd1);
    show(1, 8'h7F, 5);
    show(4, 8'h4F, 5);
    show(5, 8'h00, 5);
    show(6, 8'h7C, 5);
    show(7, 8'h3F, 5);
    tick(2);
    chk("frameC_fv", 32'(fv_cnt - fv0), 32'd1);
    chk("frameC_se", 32'(se_cnt - se0), 32'd1);
    chk("frameC_pe", 32'(pe_cnt - pe0), 32'd0);
    chk_out("frameC", 32'h0B03F284, 8'h20, 8'h00);

    // Position 7 never shown: frame must time out.
    wait_timeout();
    fv0 = fv_cnt;
    for (int p = 0; p < 7; p++) show(p, 8'h07, 5);
    wait_timeout();
    chk("to_interval", 32'(to_last - to_prev), 32'd64);
    chk("to_no_fv", 32'(fv_cnt - fv0), 32'd0);
    chk_out("to_hold", 32'h0B03F284, 8'h20, 8'h00);

    // One-cycle select glitch must not capture.
    wait_timeout();
    fv0 = fv_cnt;
    show(0, 8'h5B, 5);
    show(1, 8'h77, 5);
    show(2, 8'h7C, 5);
    show(3, 8'h39, 5);
    show(4, 8'h5E, 5);
    show(5, 8'h79, 5);
    show(6, 8'h71, 5);
    show(0, 8'h7F, 1);
    show(7, 8'h6F, 5);
    tick(2);
    chk("glitch_fv", 32'(fv_cnt - fv0), 32'd1);
    chk_out("glitch", 32'h9FEDCBA2, 8'h00, 8'h00);

    // Reset mid-frame abandons the partial frame.
    wait_timeout();
    for (int p = 0; p < 4; p++) show(p, 8'h06, 5);
    rst_n = 1'b0;
    tick(2);
    chk_out("midrst", 32'h0, 8'h00, 8'h00);
    chk("midrst_fv", 32'(bus.frame_valid), 32'd0);
    chk("midrst_to", 32'(bus.timeout), 32'd0);
    rst_n = 1'b1;
    fv0 = fv_cnt;
    for (int p = 4; p < 8; p++) show(p, 8'h06, 5);
    wait_timeout();
    chk("midrst_no_fv", 32'(fv_cnt - fv0), 32'd0);
    chk_out("midrst_after", 32'h0, 8'h00, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

endmodule
